// File: rtl/egress_pkg.sv
// egress_pkg: shared states, register map and timing constants for the egress reader.
package egress_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, HOLD} state_t;
  localparam logic [1:0] ADDR_META   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DELIV  = 2'd2;
  localparam logic [1:0] ADDR_DROP   = 2'd3;
  localparam int STAT_VALID = 31;
  localparam int STAT_OVF   = 30;
  localparam logic [1:0] WAIT_CYCLES = 2'd2;
endpackage

// File: rtl/egress_occupancy.sv
// egress_occupancy: saturating up/down occupancy counter of the egress queue with sticky overflow.
module egress_occupancy #(
  parameter int PACKET_CNT = 1024,
  localparam int CW = $clog2(PACKET_CNT) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          ovf_evt
);
  logic full;
  assign full = count == CW'(PACKET_CNT);
  // A write and a pop in the same cycle cancel, so only a lone write into a full queue overflows.
  assign ovf_evt = inc & ~dec & full;
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= (inc & ~dec & ~full) ? count + CW'(1) :
               (dec & ~inc & (count != '0)) ? count - CW'(1) : count;
      ovf   <= ovf_evt | (ovf & ~clr);
    end
  end
endmodule

// File: rtl/egress_reader.sv
// egress_reader: drains the egress metadata queue one entry at a time and exposes it over Avalon-MM.
// Optional EGRESS_READER_STATS_EN adds delivered/drop counters at addresses 2 and 3.
module egress_reader
  import egress_pkg::*;
#(
  parameter int PACKET_CNT = 1024,
  parameter int META_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  egress_in_en,
  input  logic [META_WIDTH-1:0] egress_out,
  output logic                  egress_in_ack,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic [1:0]            address,
  output logic [31:0]           readdata,
  output logic                  irq
);
  localparam int CW = $clog2(PACKET_CNT) + 1;
  state_t state, state_n;
  logic [1:0] wcnt, wcnt_n;
  logic [META_WIDTH-1:0] hold;
  logic [CW-1:0] count;
  logic ovf, ovf_evt, rd, pop, valid;
  logic [31:0] status, rd_mux, deliv, drop;
  assign valid = state == HOLD;
  assign irq = valid;
  assign egress_in_ack = state == CAPTURE;
  assign rd = chipselect & read;
  assign pop = rd & (address == ADDR_META) & valid;
  egress_occupancy #(.PACKET_CNT(PACKET_CNT)) u_occ (
    .clk(clk),
    .reset(reset),
    .inc(egress_in_en),
    .dec(egress_in_ack),
    .clr(rd & (address == ADDR_STATUS)),
    .count(count),
    .ovf(ovf),
    .ovf_evt(ovf_evt)
  );
  always_comb begin
    state_n = state;
    wcnt_n = wcnt;
    unique case (state)
      IDLE: if (count != '0) begin
        state_n = WAIT;
        wcnt_n = WAIT_CYCLES;
      end
      // The wait absorbs the registered RAM read and a read-during-write on a just-written head.
      WAIT: begin
        wcnt_n = wcnt - 2'd1;
        state_n = (wcnt == 2'd1) ? CAPTURE : WAIT;
      end
      CAPTURE: state_n = HOLD;
      HOLD: state_n = pop ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wcnt <= '0;
      hold <= '0;
      readdata <= '0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      if (state == CAPTURE) hold <= egress_out;
      if (rd) readdata <= rd_mux;
    end
  end
  always_comb begin
    status = '0;
    status[CW-1:0] = count;
    status[STAT_OVF] = ovf;
    status[STAT_VALID] = valid;
  end
  assign rd_mux = (address == ADDR_META) ? (valid ? 32'(hold) : 32'd0) :
                  (address == ADDR_STATUS) ? status :
                  (address == ADDR_DELIV) ? deliv : drop;
`ifdef EGRESS_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      deliv <= '0;
      drop <= '0;
    end else begin
      if (pop) deliv <= deliv + 32'd1;
      if (ovf_evt) drop <= drop + 32'd1;
    end
  end
`else
  logic unused_ovf_evt;
  assign unused_ovf_evt = ovf_evt;
  assign deliv = '0;
  assign drop = '0;
`endif
endmodule

// File: tb/tb_egress_reader.sv
// tb_egress_reader: self-checking bench with an upstream queue fixture and a scoreboard of delivered entries.
module tb_egress_reader;
  localparam int PC = 1024;
  logic clk = 0, reset = 0, egress_in_en = 0, chipselect = 0, read = 0;
  logic [1:0] address = 0;
  logic [31:0] egress_out, readdata, wdata = 0;
  logic egress_in_ack, irq;
  logic [31:0] mem [PC];
  logic [9:0] wr_i, rd_i;
  int acks = 0, errors = 0, checks = 0;
  bit bad_ack = 0;
  always #5 clk = ~clk;
  egress_reader #(.PACKET_CNT(PC), .META_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .egress_in_en(egress_in_en), .egress_out(egress_out),
    .egress_in_ack(egress_in_ack), .chipselect(chipselect), .read(read),
    .address(address), .readdata(readdata), .irq(irq)
  );
  // Upstream queue with a registered read port; its indices reset together with the DUT.
  always @(posedge clk) begin
    if (!reset) begin
      wr_i <= 0;
      rd_i <= 0;
      egress_out <= 0;
    end else begin
      if (egress_in_en) begin
        mem[wr_i] <= wdata;
        wr_i <= wr_i + 1;
      end
      if (egress_in_ack) rd_i <= rd_i + 1;
      egress_out <= mem[rd_i];
    end
    if (egress_in_ack) acks <= acks + 1;
    if (egress_in_ack && irq) bad_ack <= 1;
  end
  task tick; @(posedge clk); #1; endtask
  task do_reset; reset = 0; tick; tick; reset = 1; endtask
  task push(input logic [31:0] d); egress_in_en = 1; wdata = d; tick; egress_in_en = 0; endtask
  task rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1; read = 1; address = a; tick; chipselect = 0; read = 0; d = readdata;
  endtask
  task wait_irq(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (irq) begin ok = 1; break; end
      tick;
    end
  endtask

  task test_reset;
    logic [31:0] d;
    do_reset;
    checks++; if (egress_in_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", egress_in_ack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp 0", readdata); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", a, d); end
    end
  endtask

  task test_single;
    logic [31:0] d;
    int lat;
    do_reset;
    push(32'hDEADBEEF);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (egress_in_ack) begin lat = k; break; end
      tick;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_ack_latency got %0d exp 4", lat); end
    tick;
    checks++; if (egress_in_ack !== 1'b0) begin errors++; $display("FAIL single_ack_width got %b exp 0", egress_in_ack); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq got %b exp 1", irq); end
    rd(0, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_fall got %b exp 0", irq); end
    rd(1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_status got %h exp 0", d); end
  endtask

  task test_back_to_back;
    logic [31:0] d;
    bit ok;
    int a0;
    do_reset;
    a0 = acks;
    push(32'h1); push(32'h2); push(32'h3);
    wait_irq(ok);
    rd(1, d);
    checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL b2b_status got %h exp 80000002", d); end
    for (int i = 0; i < 3; i++) begin
      wait_irq(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout entry %0d got no irq exp irq", i); end
      rd(0, d);
      checks++; if (d !== 32'(i + 1)) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, d, i + 1); end
    end
    repeat (6) tick;
    checks++; if (acks - a0 !== 3) begin errors++; $display("FAIL b2b_acks got %0d exp 3", acks - a0); end
  endtask

  task test_simultaneous;
    logic [31:0] d;
    bit ok;
    do_reset;
    push(32'hAAAA_0001);
    tick; tick;
    rd(1, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL simul_before got %h exp 00000001", d); end
    checks++; if (egress_in_ack !== 1'b1) begin errors++; $display("FAIL simul_ack got %b exp 1", egress_in_ack); end
    push(32'hBBBB_0002);
    rd(1, d);
    checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL simul_after got %h exp 80000001", d); end
    rd(0, d);
    checks++; if (d !== 32'hAAAA_0001) begin errors++; $display("FAIL simul_data0 got %h exp aaaa0001", d); end
    wait_irq(ok);
    rd(0, d);
    checks++; if (d !== 32'hBBBB_0002) begin errors++; $display("FAIL simul_data1 got %h exp bbbb0002", d); end
  endtask

  task test_empty;
    logic [31:0] d;
    int a0;
    do_reset;
    a0 = acks;
    rd(0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL empty_data got %h exp 0", d); end
    repeat (6) tick;
    checks++; if (acks !== a0) begin errors++; $display("FAIL empty_acks got %0d exp %0d", acks, a0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL empty_irq got %b exp 0", irq); end
  endtask

  task test_overflow;
    logic [31:0] d;
    do_reset;
    egress_in_en = 1;
    for (int i = 0; i < PC + 2; i++) begin
      wdata = 32'h100 + 32'(i);
      tick;
    end
    egress_in_en = 0;
    repeat (8) tick;
    rd(1, d);
    checks++; if (d !== 32'hC000_0400) begin errors++; $display("FAIL ovf_status got %h exp c0000400", d); end
    rd(1, d);
    checks++; if (d !== 32'h8000_0400) begin errors++; $display("FAIL ovf_clear got %h exp 80000400", d); end
    rd(3, d);
`ifdef EGRESS_READER_STATS_EN
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ovf_drop got %h exp 1", d); end
`else
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_drop got %h exp 0", d); end
`endif
    rd(0, d);
    checks++; if (d !== 32'h100) begin errors++; $display("FAIL ovf_head got %h exp 100", d); end
    rd(2, d);
`ifdef EGRESS_READER_STATS_EN
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ovf_deliv got %h exp 1", d); end
`else
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_deliv got %h exp 0", d); end
`endif
  endtask

  task test_random;
    logic [31:0] d, e;
    logic [31:0] q[$];
    bit ok;
    int a0, n, total;
    do_reset;
    a0 = acks;
    total = 0;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        d = $urandom;
        q.push_back(d);
        push(d);
        repeat ($urandom_range(0, 2)) tick;
      end
      total += n;
      repeat (8) tick;
      rd(1, d);
      checks++; if (d !== (32'h8000_0000 | 32'(n - 1))) begin errors++; $display("FAIL rand_status r%0d got %h exp %h", r, d, 32'h8000_0000 | 32'(n - 1)); end
      while (q.size() > 0) begin
        wait_irq(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_timeout r%0d got no irq exp irq", r); end
        rd(0, d);
        e = q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL rand_data r%0d got %h exp %h", r, d, e); end
      end
    end
    repeat (6) tick;
    checks++; if (acks - a0 !== total) begin errors++; $display("FAIL rand_acks got %0d exp %0d", acks - a0, total); end
  endtask

  task test_reset_hold;
    logic [31:0] d;
    bit ok;
    do_reset;
    push(32'h55);
    wait_irq(ok);
    rd(1, d);
    reset = 0;
    tick;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rsthold_irq got %b exp 0", irq); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rsthold_readdata got %h exp 0", readdata); end
    checks++; if (egress_in_ack !== 1'b0) begin errors++; $display("FAIL rsthold_ack got %b exp 0", egress_in_ack); end
    reset = 1;
    rd(1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rsthold_status got %h exp 0", d); end
    repeat (6) tick;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rsthold_irq_late got %b exp 0", irq); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_simultaneous;
    test_empty;
    test_overflow;
    test_random;
    test_reset_hold;
    checks++; if (bad_ack !== 1'b0) begin errors++; $display("FAIL ack_while_valid got %b exp 0", bad_ack); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
